// File: rtl/icache_set_assoc.sv
// Set-associative instruction cache with multi-word lines, word-at-a-time refill
// from memctrl, per-set round-robin replacement and whole-cache flush.
module icache_set_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  valid_from_ifetch,
  input  logic [ADDR_WIDTH-1:0] pc_from_ifetch,
  output logic                  valid_to_ifetch,
  output logic [31:0]           data_to_ifetch,
  output logic                  valid_to_memctrl,
  output logic [ADDR_WIDTH-1:0] addr_to_memctrl,
  input  logic                  valid_from_memctrl,
  input  logic [31:0]           data_from_memctrl,
  output logic                  busy
);

  localparam int SETS     = 1 << INDEX_BITS;
  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFF_BITS - 2;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                  state_q;
  logic [OFF_W-1:0]        cnt_q;
  logic [INDEX_BITS-1:0]   fill_idx_q;
  logic [TAG_BITS-1:0]     fill_tag_q;
  logic [WAY_W-1:0]        victim_q;
  logic                    discard_q;

  logic [SETS-1:0]         valid_q [WAYS];
  logic [WAY_W-1:0]        rr_q    [SETS];
  logic [TAG_BITS-1:0]     tag_q   [WAYS][SETS];
  logic [31:0]             data_q  [WAYS][SETS][LINE_WORDS];

  logic [INDEX_BITS-1:0]   pc_idx;
  logic [TAG_BITS-1:0]     pc_tag;
  logic [OFF_W-1:0]        pc_off;
  logic                    hit_raw;
  logic [31:0]             hit_data;
  logic [WAY_W-1:0]        victim;
  logic                    last_word;

  assign pc_idx    = INDEX_BITS'(pc_from_ifetch >> (OFF_BITS + 2));
  assign pc_tag    = TAG_BITS'(pc_from_ifetch >> (OFF_BITS + INDEX_BITS + 2));
  assign pc_off    = OFF_W'((pc_from_ifetch >> 2) & ADDR_WIDTH'(LINE_WORDS - 1));
  assign last_word = (cnt_q == OFF_W'(LINE_WORDS - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit_raw  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][pc_idx] && (tag_q[w][pc_idx] == pc_tag)) begin
        hit_raw  = 1'b1;
        hit_data = data_q[w][pc_idx][pc_off];
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise fall back to the set's round-robin pointer.
  always_comb begin
    victim = rr_q[pc_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][pc_idx]) victim = WAY_W'(w);
    end
  end

  assign valid_to_ifetch = valid_from_ifetch && hit_raw && !flush;
  assign data_to_ifetch  = valid_to_ifetch ? hit_data : 32'h0;
  assign busy            = (state_q == REFILL);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      fill_idx_q       <= '0;
      fill_tag_q       <= '0;
      victim_q         <= '0;
      discard_q        <= 1'b0;
      valid_to_memctrl <= 1'b0;
      addr_to_memctrl  <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      end
      case (state_q)
        IDLE: begin
          if (valid_from_ifetch && !flush && !hit_raw) begin
            state_q          <= REFILL;
            valid_to_memctrl <= 1'b1;
            addr_to_memctrl  <= pc_from_ifetch & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
            cnt_q            <= '0;
            fill_idx_q       <= pc_idx;
            fill_tag_q       <= pc_tag;
            victim_q         <= victim;
            discard_q        <= 1'b0;
          end
        end
        REFILL: begin
          if (flush) discard_q <= 1'b1;
          if (valid_from_memctrl) begin
            if (!last_word) begin
              cnt_q           <= cnt_q + 1'b1;
              addr_to_memctrl <= addr_to_memctrl + ADDR_WIDTH'(4);
            end else begin
              // A flush seen at any point of the fill, including this edge, keeps the line invalid.
              if (!discard_q && !flush) valid_q[victim_q][fill_idx_q] <= 1'b1;
              if (victim_q == rr_q[fill_idx_q]) begin
                rr_q[fill_idx_q] <= (rr_q[fill_idx_q] == WAY_W'(WAYS - 1)) ? '0
                                    : rr_q[fill_idx_q] + 1'b1;
              end
              valid_to_memctrl <= 1'b0;
              discard_q        <= 1'b0;
              state_q          <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data storage are not reset; the valid bits alone decide whether their contents count.
  always_ff @(posedge clk) begin
    if (rdy && (state_q == REFILL) && valid_from_memctrl) begin
      data_q[victim_q][fill_idx_q][cnt_q] <= data_from_memctrl;
      if (last_word) tag_q[victim_q][fill_idx_q] <= fill_tag_q;
    end
  end

endmodule

// File: tb/tb_icache_set_assoc.sv
// Self-checking bench for icache_set_assoc: a memctrl responder pops expected
// request addresses from a scoreboard queue; hits are checked combinationally.
module tb_icache_set_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        valid_from_ifetch;
  logic [31:0] pc_from_ifetch;
  logic        valid_to_ifetch;
  logic [31:0] data_to_ifetch;
  logic        valid_to_memctrl;
  logic [31:0] addr_to_memctrl;
  logic        valid_from_memctrl;
  logic [31:0] data_from_memctrl;
  logic        busy;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_addr[$];

  icache_set_assoc dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .flush              (flush),
    .valid_from_ifetch  (valid_from_ifetch),
    .pc_from_ifetch     (pc_from_ifetch),
    .valid_to_ifetch    (valid_to_ifetch),
    .data_to_ifetch     (data_to_ifetch),
    .valid_to_memctrl   (valid_to_memctrl),
    .addr_to_memctrl    (addr_to_memctrl),
    .valid_from_memctrl (valid_from_memctrl),
    .data_from_memctrl  (data_from_memctrl),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000100) return 32'hA0 + 32'(a[3:2]);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr.push_back(base + 32'(4 * i));
  endtask

  // Memctrl responder: serves one 4-word line with the given latency, optional
  // flush pulse while waiting on word flush_word, optional 5-cycle rdy stall before word stall_word.
  task automatic serve_line(input int lat, input int flush_word, input int stall_word);
    logic [31:0] exp;
    int n;
    for (int w = 0; w < 4; w++) begin
      n = 0;
      while (!valid_to_memctrl && n < 50) begin
        tick();
        n++;
      end
      checks++;
      if (!valid_to_memctrl || exp_addr.size() == 0) begin
        $display("FAIL req_wait word %0d: valid_to_memctrl=%0b queued=%0d, required a request", w,
                 valid_to_memctrl, exp_addr.size());
        exp_addr.delete();
        rdy = 1'b1;
        return;
      end
      passes++;
      exp = exp_addr.pop_front();
      checks++;
      if (addr_to_memctrl !== exp)
        $display("FAIL req_addr word %0d: got %h, required %h", w, addr_to_memctrl, exp);
      else passes++;
      for (int c = 1; c < lat; c++) begin
        if (w == flush_word && c == 1) flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (valid_to_memctrl !== 1'b1 || addr_to_memctrl !== exp || valid_to_ifetch !== 1'b0 || busy !== 1'b1)
          $display("FAIL req_hold word %0d: valid=%0b addr=%h hit=%0b busy=%0b, required 1/%h/0/1", w,
                   valid_to_memctrl, addr_to_memctrl, valid_to_ifetch, busy, exp);
        else passes++;
      end
      if (w == stall_word) begin
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
          tick();
          checks++;
          if (valid_to_memctrl !== 1'b1 || addr_to_memctrl !== exp || busy !== 1'b1)
            $display("FAIL stall_hold word %0d: valid=%0b addr=%h busy=%0b, required 1/%h/1", w,
                     valid_to_memctrl, addr_to_memctrl, busy, exp);
          else passes++;
        end
        rdy = 1'b1;
      end
      valid_from_memctrl = 1'b1;
      data_from_memctrl  = mem_word(exp);
      tick();
      valid_from_memctrl = 1'b0;
      data_from_memctrl  = '0;
    end
    checks++;
    if (busy !== 1'b0 || valid_to_memctrl !== 1'b0)
      $display("FAIL refill_done: busy=%0b valid_to_memctrl=%0b, required 0/0", busy, valid_to_memctrl);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    valid_from_ifetch = 1'b1; pc_from_ifetch = 32'h1000;
    valid_from_memctrl = 1'b0; data_from_memctrl = '0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || valid_to_memctrl !== 1'b0 || addr_to_memctrl !== 32'h0)
      $display("FAIL reset_outputs: busy=%0b valid=%0b addr=%h, required 0/0/0", busy, valid_to_memctrl,
               addr_to_memctrl);
    else passes++;
    checks++;
    if (valid_to_ifetch !== 1'b0 || data_to_ifetch !== 32'h0)
      $display("FAIL reset_no_hit: hit=%0b data=%h, required 0/0", valid_to_ifetch, data_to_ifetch);
    else passes++;
    valid_from_ifetch = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fill_and_hit();
    pc_from_ifetch = 32'h1000; valid_from_ifetch = 1'b1;
    push_line(32'h1000);
    serve_line(2, -1, -1);
    pc_from_ifetch = 32'h1008;
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b1 || data_to_ifetch !== 32'hA2)
      $display("FAIL hit_1008: hit=%0b data=%h, required 1/000000a2", valid_to_ifetch, data_to_ifetch);
    else passes++;
  endtask

  task automatic test_replacement();
    pc_from_ifetch = 32'h1400;
    push_line(32'h1400);
    serve_line(1, -1, -1);
    pc_from_ifetch = 32'h1800;
    push_line(32'h1800);
    serve_line(1, -1, -1);
    pc_from_ifetch = 32'h1000;
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b0 || data_to_ifetch !== 32'h0)
      $display("FAIL evicted_1000: hit=%0b data=%h, required 0/0", valid_to_ifetch, data_to_ifetch);
    else passes++;
    pc_from_ifetch = 32'h1404;
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b1 || data_to_ifetch !== mem_word(32'h1404))
      $display("FAIL kept_1404: hit=%0b data=%h, required 1/%h", valid_to_ifetch, data_to_ifetch,
               mem_word(32'h1404));
    else passes++;
    pc_from_ifetch = 32'h180C;
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b1 || data_to_ifetch !== mem_word(32'h180C))
      $display("FAIL new_180c: hit=%0b data=%h, required 1/%h", valid_to_ifetch, data_to_ifetch,
               mem_word(32'h180C));
    else passes++;
  endtask

  task automatic test_slow_memctrl();
    pc_from_ifetch = 32'h2000;
    push_line(32'h2000);
    serve_line(11, -1, -1);
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b1 || data_to_ifetch !== mem_word(32'h2000))
      $display("FAIL hit_2000: hit=%0b data=%h, required 1/%h", valid_to_ifetch, data_to_ifetch,
               mem_word(32'h2000));
    else passes++;
  endtask

  task automatic test_flush();
    pc_from_ifetch = 32'h1000;
    push_line(32'h1000);
    serve_line(1, -1, -1);
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b1 || data_to_ifetch !== 32'hA0)
      $display("FAIL refetch_1000: hit=%0b data=%h, required 1/000000a0", valid_to_ifetch, data_to_ifetch);
    else passes++;
    flush = 1'b1;
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b0)
      $display("FAIL flush_suppress: hit=%0b, required 0", valid_to_ifetch);
    else passes++;
    flush = 1'b0;
    pc_from_ifetch = 32'h3000;
    push_line(32'h3000);
    serve_line(3, 2, -1);
    valid_from_ifetch = 1'b1;
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b0)
      $display("FAIL discarded_3000: hit=%0b, required 0", valid_to_ifetch);
    else passes++;
    pc_from_ifetch = 32'h1000;
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b0)
      $display("FAIL flushed_1000: hit=%0b, required 0", valid_to_ifetch);
    else passes++;
    valid_from_ifetch = 1'b0;
    tick();
  endtask

  task automatic test_rdy_stall();
    valid_from_ifetch = 1'b1;
    pc_from_ifetch = 32'h4000;
    push_line(32'h4000);
    serve_line(2, -1, 1);
    for (int i = 0; i < 4; i++) begin
      pc_from_ifetch = 32'h4000 + 32'(4 * i);
      #1;
      checks++;
      if (valid_to_ifetch !== 1'b1 || data_to_ifetch !== mem_word(pc_from_ifetch))
        $display("FAIL stall_data %h: hit=%0b data=%h, required 1/%h", pc_from_ifetch, valid_to_ifetch,
                 data_to_ifetch, mem_word(pc_from_ifetch));
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    int n;
    pc_from_ifetch = 32'h1000;
    n = 0;
    while (!valid_to_memctrl && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (valid_to_memctrl !== 1'b1 || busy !== 1'b1)
      $display("FAIL pre_reset_refill: valid=%0b busy=%0b, required 1/1", valid_to_memctrl, busy);
    else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid_to_memctrl !== 1'b0 || busy !== 1'b0 || addr_to_memctrl !== 32'h0)
      $display("FAIL async_reset: valid=%0b busy=%0b addr=%h, required 0/0/0", valid_to_memctrl, busy,
               addr_to_memctrl);
    else passes++;
    tick();
    rst = 1'b0;
    pc_from_ifetch = 32'h4000;
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b0)
      $display("FAIL reset_cleared_4000: hit=%0b, required 0", valid_to_ifetch);
    else passes++;
    pc_from_ifetch = 32'h1000;
    push_line(32'h1000);
    serve_line(1, -1, -1);
    #1;
    checks++;
    if (valid_to_ifetch !== 1'b1 || data_to_ifetch !== 32'hA0)
      $display("FAIL post_reset_1000: hit=%0b data=%h, required 1/000000a0", valid_to_ifetch, data_to_ifetch);
    else passes++;
    valid_from_ifetch = 1'b0;
    checks++;
    if (exp_addr.size() != 0)
      $display("FAIL scoreboard_left: %0d queued, required 0", exp_addr.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_fill_and_hit();
    test_replacement();
    test_slow_memctrl();
    test_flush();
    test_rdy_stall();
    test_async_reset();
    repeat (2) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
